// File: rtl/ppm_frame_sequencer.sv
// rtl/ppm_frame_sequencer.sv - PPM sum-stream decoder committing NUM_CHANNELS on/off channels per frame
//
// Measures rising-edge-to-rising-edge intervals of a synchronised PPM stream,
// hunts for the sync gap, thresholds each channel interval with hysteresis
// into a shadow register and commits the whole frame at the closing sync gap.
// Loss of edges for TIMEOUT_VALUE counts drives all channels to 0 (failsafe).
module ppm_frame_sequencer #(
   parameter int NUM_CHANNELS       = 4,
   parameter int CNT_WIDTH          = 15,
   parameter int MIN_COUNTER_VALUE  = 900,
   parameter int MAX_COUNTER_VALUE  = 2000,
   parameter int HIGH_COUNTER_VALUE = 1800,
   parameter int LOW_COUNTER_VALUE  = 1200,
   parameter int SYNC_MIN_VALUE     = 3000,
   parameter int TIMEOUT_VALUE      = 25000
) (
   input  logic                    clock_i,
   input  logic                    reset_n_i,
   input  logic                    enable_i,
   input  logic                    ppm_i,
   output logic [NUM_CHANNELS-1:0] channel_o,
   output logic                    frame_valid_o,
   output logic                    frame_strobe_o,
   output logic [2:0]              channel_index_o,
   output logic                    error_o
);

   // Wide enough to hold NUM_CHANNELS itself (the "all channels seen" value).
   localparam int IDX_WIDTH = 4;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] MIN_C     = CNT_WIDTH'(MIN_COUNTER_VALUE);
   localparam logic [CNT_WIDTH-1:0] MAX_C     = CNT_WIDTH'(MAX_COUNTER_VALUE);
   localparam logic [CNT_WIDTH-1:0] HIGH_C    = CNT_WIDTH'(HIGH_COUNTER_VALUE);
   localparam logic [CNT_WIDTH-1:0] LOW_C     = CNT_WIDTH'(LOW_COUNTER_VALUE);
   localparam logic [CNT_WIDTH-1:0] SYNC_C    = CNT_WIDTH'(SYNC_MIN_VALUE);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT_VALUE);
   localparam logic [IDX_WIDTH-1:0] NUM_C     = IDX_WIDTH'(NUM_CHANNELS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HUNT  = 2'd1,
      ST_FRAME = 2'd2
   } state_t;

   // sync_q[0], sync_q[1]: two-flop synchroniser; sync_q[2]: delay flop for edge detect
   logic [2:0]              sync_q, sync_d;
   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    counter_q, counter_d;
   logic                    armed_q, armed_d;
   logic [IDX_WIDTH-1:0]    idx_q, idx_d;
   logic [NUM_CHANNELS-1:0] shadow_q, shadow_d;
   logic [NUM_CHANNELS-1:0] channel_q, channel_d;
   logic                    valid_q, valid_d;
   logic                    strobe_q, strobe_d;
   logic                    error_q, error_d;

   logic ppm_edge;
   logic in_range;
   logic is_sync;
   logic timeout;

   // Synchroniser shift and interval classification of the current count
   always_comb begin
      sync_d   = {sync_q[1:0], ppm_i};
      ppm_edge = sync_q[1] & ~sync_q[2];
      in_range = (counter_q >= MIN_C) && (counter_q <= MAX_C);
      is_sync  = (counter_q >= SYNC_C);
      timeout  = (counter_q == TIMEOUT_C);
   end

   // Interval counter: cleared while disabled, restarts at 1 on each edge, saturates
   always_comb begin
      counter_d = counter_q;
      if (!enable_i) begin
         counter_d = '0;
      end else if (ppm_edge) begin
         counter_d = CNT_ONE;
      end else if (counter_q != CNT_MAX) begin
         counter_d = counter_q + CNT_ONE;
      end
   end

   // Frame FSM: next state, channel capture, commit, error and failsafe handling
   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      channel_d = channel_q;
      valid_d   = valid_q;
      strobe_d  = 1'b0;
      error_d   = 1'b0;

      if (!enable_i) begin
         state_d = ST_IDLE;
         armed_d = 1'b0;
         idx_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_HUNT;
               armed_d = 1'b0;
               idx_d   = '0;
            end

            ST_HUNT: begin
               if (ppm_edge) begin
                  // The first edge after entering HUNT only opens an interval.
                  if (!armed_q) begin
                     armed_d = 1'b1;
                  end else if (is_sync) begin
                     state_d = ST_FRAME;
                     idx_d   = '0;
                  end
               end else if (timeout) begin
                  channel_d = '0;
                  valid_d   = 1'b0;
                  error_d   = 1'b1;
                  armed_d   = 1'b0;
               end
            end

            ST_FRAME: begin
               if (ppm_edge) begin
                  if (in_range) begin
                     // Channels beyond NUM_CHANNELS are legal but ignored.
                     if (idx_q < NUM_C) begin
                        for (int k = 0; k < NUM_CHANNELS; k++) begin
                           if (idx_q == IDX_WIDTH'(k)) begin
                              if (counter_q >= HIGH_C) begin
                                 shadow_d[k] = 1'b1;
                              end else if (counter_q <= LOW_C) begin
                                 shadow_d[k] = 1'b0;
                              end else begin
                                 shadow_d[k] = channel_q[k];
                              end
                           end
                        end
                        idx_d = idx_q + 1'b1;
                     end
                  end else if (is_sync) begin
                     if (idx_q >= NUM_C) begin
                        channel_d = shadow_q;
                        valid_d   = 1'b1;
                        strobe_d  = 1'b1;
                     end else begin
                        // Short frame: drop it but stay locked to the sync gap.
                        error_d = 1'b1;
                     end
                     idx_d = '0;
                  end else begin
                     error_d = 1'b1;
                     state_d = ST_HUNT;
                     armed_d = 1'b0;
                     idx_d   = '0;
                  end
               end else if (timeout) begin
                  channel_d = '0;
                  valid_d   = 1'b0;
                  error_d   = 1'b1;
                  state_d   = ST_HUNT;
                  armed_d   = 1'b0;
                  idx_d     = '0;
               end
            end

            default: begin
               state_d = ST_IDLE;
               armed_d = 1'b0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_q    <= '0;
         state_q   <= ST_IDLE;
         counter_q <= '0;
         armed_q   <= 1'b0;
         idx_q     <= '0;
         shadow_q  <= '0;
         channel_q <= '0;
         valid_q   <= 1'b0;
         strobe_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         counter_q <= counter_d;
         armed_q   <= armed_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         channel_q <= channel_d;
         valid_q   <= valid_d;
         strobe_q  <= strobe_d;
         error_q   <= error_d;
      end
   end

   assign channel_o       = channel_q;
   assign frame_valid_o   = valid_q;
   assign frame_strobe_o  = strobe_q;
   assign error_o         = error_q;
   assign channel_index_o = (state_q == ST_FRAME) ? idx_q[2:0] : 3'd0;

endmodule

// File: tb/tb_ppm_frame_sequencer.sv
// tb/tb_ppm_frame_sequencer.sv - scoreboard bench for ppm_frame_sequencer with an interval-level reference model
`timescale 1ns/1ps
module tb_ppm_frame_sequencer;

   // Thresholds scaled by 1/10 so that many frames fit in a short run.
   localparam int NCH    = 4;
   localparam int CW     = 12;
   localparam int MINV   = 90;
   localparam int MAXV   = 200;
   localparam int HIGHV  = 180;
   localparam int LOWV   = 120;
   localparam int SYNCV  = 300;
   localparam int TOV    = 2500;
   localparam int CNTSAT = (1 << CW) - 1;
   localparam int PW     = 10;

   localparam int KIND_ERR    = 1;
   localparam int KIND_STROBE = 2;

   localparam int HUNT_COLD  = 0;
   localparam int HUNT_ARMED = 1;
   localparam int IN_FRAME   = 2;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           en    = 1'b0;
   logic           ppm   = 1'b0;
   logic [NCH-1:0] channel_o;
   logic           frame_valid_o;
   logic           frame_strobe_o;
   logic [2:0]     channel_index_o;
   logic           error_o;

   ppm_frame_sequencer #(
      .NUM_CHANNELS      (NCH),
      .CNT_WIDTH         (CW),
      .MIN_COUNTER_VALUE (MINV),
      .MAX_COUNTER_VALUE (MAXV),
      .HIGH_COUNTER_VALUE(HIGHV),
      .LOW_COUNTER_VALUE (LOWV),
      .SYNC_MIN_VALUE    (SYNCV),
      .TIMEOUT_VALUE     (TOV)
   ) dut (
      .clock_i        (clk),
      .reset_n_i      (rst_n),
      .enable_i       (en),
      .ppm_i          (ppm),
      .channel_o      (channel_o),
      .frame_valid_o  (frame_valid_o),
      .frame_strobe_o (frame_strobe_o),
      .channel_index_o(channel_index_o),
      .error_o        (error_o)
   );

   always #500 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int kind;
      int ch;
      int valid;
      int at;
   } exp_t;

   exp_t sb[$];

   // Reference model state, advanced once per PPM rising edge
   int           m_mode;
   int           m_idx;
   bit [NCH-1:0] m_shadow;
   bit [NCH-1:0] m_ch;
   bit           m_valid;
   int           m_last;

   task automatic push(input int kind, input int at);
      exp_t e;
      e.kind  = kind;
      e.ch    = int'(m_ch);
      e.valid = int'(m_valid);
      e.at    = at;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_mode   = HUNT_COLD;
      m_idx    = 0;
      m_shadow = '0;
      m_ch     = '0;
      m_valid  = 1'b0;
      m_last   = 0;
   endtask

   task automatic model_disable();
      m_mode  = HUNT_COLD;
      m_idx   = 0;
      m_valid = 1'b0;
   endtask

   // A rise driven at cycle p becomes visible on the outputs at cycle p+3.
   task automatic model_rise(input int p);
      int iv;
      iv = p - m_last;
      if (iv > CNTSAT) iv = CNTSAT;
      m_last = p;
      case (m_mode)
         HUNT_COLD:  m_mode = HUNT_ARMED;
         HUNT_ARMED: if (iv >= SYNCV) begin m_mode = IN_FRAME; m_idx = 0; end
         default: begin
            if (iv >= MINV && iv <= MAXV) begin
               if (m_idx < NCH) begin
                  if (iv >= HIGHV)     m_shadow[m_idx] = 1'b1;
                  else if (iv <= LOWV) m_shadow[m_idx] = 1'b0;
                  else                 m_shadow[m_idx] = m_ch[m_idx];
                  m_idx++;
               end
            end else if (iv >= SYNCV) begin
               if (m_idx >= NCH) begin
                  m_ch    = m_shadow;
                  m_valid = 1'b1;
                  push(KIND_STROBE, p + 3);
               end else begin
                  push(KIND_ERR, p + 3);
               end
               m_idx = 0;
            end else begin
               m_mode = HUNT_COLD;
               m_idx  = 0;
               push(KIND_ERR, p + 3);
            end
         end
      endcase
   endtask

   // A silent gap longer than the timeout trips the failsafe once.
   task automatic model_gap(input int p, input int n);
      if (n > TOV) begin
         m_ch    = '0;
         m_valid = 1'b0;
         m_mode  = HUNT_COLD;
         m_idx   = 0;
         push(KIND_ERR, p + 3 + TOV);
      end
   endtask

   // Drive one rising edge, then wait so the next rise comes n cycles later.
   task automatic rise(input int n);
      int p;
      @(posedge clk);
      #1;
      ppm = 1'b1;
      p   = cyc;
      model_rise(p);
      model_gap(p, n);
      repeat (PW) @(posedge clk);
      #1 ppm = 1'b0;
      repeat (n - PW - 1) @(posedge clk);
   endtask

   // Monitor: pop the expected pulse whenever the DUT strobes or errors
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].at < cyc) begin
            mon_e = sb.pop_front();
            check("missed_pulse_cycle", cyc, mon_e.at);
         end
         if (frame_strobe_o || error_o) begin
            if (sb.size() == 0) begin
               check("spurious_pulse_cycle", cyc, -1);
            end else begin
               mon_e = sb.pop_front();
               check("pulse_kind", int'({frame_strobe_o, error_o}), mon_e.kind);
               check("pulse_cycle", cyc, mon_e.at);
               check("channel_o", int'(channel_o), mon_e.ch);
               check("frame_valid_o", int'(frame_valid_o), mon_e.valid);
               check("channel_index_o", int'(channel_index_o), 0);
            end
         end
      end
   end

   int dir[$] = '{400, 190, 100, 150, 190, 400, 190, 100, 185, 190, 400,
                  190, 100, 150, 190, 400, 190, 100, 110, 190, 400,
                  190, 190, 190, 400, 190, 50, 190, 400,
                  190, 190, 190, 190, 190, 350, 90, 120, 180, 200, 300,
                  89, 150, 300, 121, 119, 181, 179, 300, 201, 150, 300,
                  150, 150, 150, 150, 299, 150, 2500, 150, 150, 150, 150,
                  2501, 300, 190, 100, 190, 190, 300, 190, 190, 190};
   int post[$] = '{100, 400, 190, 190, 190, 190, 400, 60};
   int bvals[9] = '{90, 91, 119, 120, 121, 179, 180, 181, 200};

   function automatic int rand_chan();
      int r;
      r = int'($urandom_range(99));
      if (r < 2)  return TOV + int'($urandom_range(1, 100));
      if (r < 7)  return int'($urandom_range(25, MINV - 1));
      if (r < 12) return int'($urandom_range(MAXV + 1, SYNCV - 1));
      if (r < 50) return bvals[$urandom_range(8)];
      return int'($urandom_range(MINV, MAXV));
   endfunction

   function automatic int rand_sync();
      if ($urandom_range(19) == 0) return TOV;
      return int'($urandom_range(SYNCV, SYNCV + 150));
   endfunction

   initial begin
      int k;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_channel_o", int'(channel_o), 0);
      check("reset_frame_valid_o", int'(frame_valid_o), 0);
      check("reset_frame_strobe_o", int'(frame_strobe_o), 0);
      check("reset_error_o", int'(error_o), 0);
      check("reset_channel_index_o", int'(channel_index_o), 0);
      rst_n = 1'b1;
      en    = 1'b1;

      foreach (dir[i]) rise(dir[i]);

      // Asynchronous reset in the middle of a frame
      check("queue_drained_before_reset", sb.size(), 0);
      check("pre_reset_channel_o", int'(channel_o), int'(m_ch));
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_channel_o", int'(channel_o), 0);
      check("async_reset_frame_valid_o", int'(frame_valid_o), 0);
      check("async_reset_channel_index_o", int'(channel_index_o), 0);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();

      foreach (post[i]) rise(post[i]);

      // Disable: frame_valid drops, committed channels are held
      #1 en = 1'b0;
      model_disable();
      repeat (3) @(posedge clk);
      #1;
      check("disabled_frame_valid_o", int'(frame_valid_o), 0);
      check("disabled_channel_o", int'(channel_o), int'(m_ch));
      check("disabled_channel_index_o", int'(channel_index_o), 0);
      en = 1'b1;

      for (int f = 0; f < 30; f++) begin
         rise(rand_sync());
         k = 4;
         case ($urandom_range(4))
            0: k = 3;
            1: k = 5;
            default: k = 4;
         endcase
         for (int c = 0; c < k; c++) rise(rand_chan());
      end

      // Final silence long enough for the failsafe timeout
      rise(TOV + 60);
      repeat (5) @(posedge clk);
      #1;
      check("queue_drained_at_end", sb.size(), 0);
      check("final_channel_o", int'(channel_o), 0);
      check("final_frame_valid_o", int'(frame_valid_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
